spi_cfg_master: RTL and testbench

Two-requester SPI transaction sequencer for the configuration register bank. It grants one requester at a time with round-robin arbitration. It serialises a 16-bit frame onto `cs`/`pico`: a `{rw, addr[6:0]}` byte followed by a data byte, both MSB first. For reads it captures `poci` and returns the byte. It sits between the host/bench command path plus the power-up config sequencer on one side, and the chip-side SPI register bank on the other.

---
 rtl/spi_cfg_master.sv | 163 ++++++++++++++++
 tb/tb_spi_cfg_master.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_cfg_master.sv
// Two-requester SPI sequencer for the config register bank: round-robin grant,
// 16-bit {rw, addr, data} frame out on cs/pico, read byte captured from poci.
module spi_cfg_master #(
  parameter int unsigned CS_GAP = 2,
  parameter int unsigned ADDR_W = 7
) (
  input  logic              spi_clk,
  input  logic              rstn,
  input  logic [1:0]        req,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [7:0]        req0_wdata,
  input  logic [7:0]        req1_wdata,
  input  logic              req0_is_write,
  input  logic              req1_is_write,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic [7:0]        rdata,
  output logic              busy,
  output logic              cs,
  output logic              pico,
  input  logic              poci
);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StGap} state_e;

  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic [16:0] sh_q, sh_d;
  logic [6:0]  rx_q, rx_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  done_q, done_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        busy_q, busy_d;
  logic        cs_q, cs_d;
  logic        last_q, last_d;
  logic        is_write_q, is_write_d;
  logic        winner_q, winner_d;

  logic        grant_ok;
  logic        win;
  logic        win_wr;
  logic [6:0]  win_addr;
  logic [7:0]  win_wdata;
  logic        gap_last;

  assign gap_last = (gap_cnt_q == 4'(CS_GAP - 1));

  // Both requesting: whoever was not served last goes next.
  always_comb begin
    win       = (req == 2'b11) ? ~last_q : req[1];
    win_wr    = win ? req1_is_write : req0_is_write;
    win_addr  = win ? 7'(req1_addr) : 7'(req0_addr);
    win_wdata = win ? req1_wdata : req0_wdata;
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    sh_d       = sh_q;
    rx_d       = rx_q;
    gnt_d      = 2'b00;
    done_d     = 2'b00;
    rdata_d    = rdata_q;
    busy_d     = busy_q;
    last_d     = last_q;
    is_write_d = is_write_q;
    winner_d   = winner_q;
    grant_ok   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (gnt_q != 2'b00) begin
          state_d   = StAddr;
          bit_cnt_d = 4'd0;
          sh_d      = {sh_q[15:0], 1'b0};
        end else begin
          grant_ok = 1'b1;
        end
      end
      StAddr: begin
        sh_d      = {sh_q[15:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd7) state_d = StData;
      end
      StData: begin
        sh_d = {sh_q[15:0], 1'b0};
        rx_d = {rx_q[5:0], poci};
        if (bit_cnt_q == 4'd15) begin
          state_d   = StGap;
          gap_cnt_d = 4'd0;
          done_d    = winner_q ? 2'b10 : 2'b01;
          rdata_d   = is_write_q ? 8'h00 : {rx_q, poci};
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      StGap: begin
        if (gap_last) begin
          state_d  = StIdle;
          busy_d   = 1'b0;
          grant_ok = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
    endcase

    // Grant is registered; sh bit 16 is a pad so pico stays 0 in the gnt cycle.
    if (grant_ok && (req != 2'b00)) begin
      gnt_d      = win ? 2'b10 : 2'b01;
      busy_d     = 1'b1;
      last_d     = win;
      winner_d   = win;
      is_write_d = win_wr;
      sh_d       = {1'b0, win_wr, win_addr, win_wr ? win_wdata : 8'h00};
    end

    cs_d = (state_d == StAddr) || (state_d == StData);
  end

  always_ff @(posedge spi_clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      bit_cnt_q  <= 4'd0;
      gap_cnt_q  <= 4'd0;
      sh_q       <= '0;
      rx_q       <= '0;
      gnt_q      <= 2'b00;
      done_q     <= 2'b00;
      rdata_q    <= 8'h00;
      busy_q     <= 1'b0;
      cs_q       <= 1'b0;
      last_q     <= 1'b1;
      is_write_q <= 1'b0;
      winner_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      sh_q       <= sh_d;
      rx_q       <= rx_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      cs_q       <= cs_d;
      last_q     <= last_d;
      is_write_q <= is_write_d;
      winner_q   <= winner_d;
    end
  end

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign rdata = rdata_q;
  assign busy  = busy_q;
  assign cs    = cs_q;
  assign pico  = sh_q[16];

endmodule

// File: tb/tb_spi_cfg_master.sv
// Directed bench for spi_cfg_master: dut_a uses CS_GAP=2, dut_b uses CS_GAP=1.
module tb_spi_cfg_master;

  logic       spi_clk = 1'b0;
  logic       rstn;
  logic [1:0] req;
  logic       use_b;
  logic [6:0] req0_addr, req1_addr;
  logic [7:0] req0_wdata, req1_wdata;
  logic       req0_is_write, req1_is_write;
  logic       poci;

  logic [1:0] req_a, req_b, gnt_a, gnt_b, done_a, done_b;
  logic [7:0] rdata_a, rdata_b;
  logic       busy_a, busy_b, cs_a, cs_b, pico_a, pico_b;

  logic [1:0] o_gnt, o_done;
  logic [7:0] o_rdata;
  logic       o_busy, o_cs, o_pico;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 spi_clk = ~spi_clk;
  always @(posedge spi_clk) cyc <= cyc + 1;

  assign req_a   = use_b ? 2'b00 : req;
  assign req_b   = use_b ? req : 2'b00;
  assign o_gnt   = use_b ? gnt_b : gnt_a;
  assign o_done  = use_b ? done_b : done_a;
  assign o_rdata = use_b ? rdata_b : rdata_a;
  assign o_busy  = use_b ? busy_b : busy_a;
  assign o_cs    = use_b ? cs_b : cs_a;
  assign o_pico  = use_b ? pico_b : pico_a;

  spi_cfg_master #(.CS_GAP(2), .ADDR_W(7)) dut_a (
    .spi_clk(spi_clk), .rstn(rstn), .req(req_a),
    .req0_addr(req0_addr), .req1_addr(req1_addr),
    .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
    .req0_is_write(req0_is_write), .req1_is_write(req1_is_write),
    .gnt(gnt_a), .done(done_a), .rdata(rdata_a), .busy(busy_a),
    .cs(cs_a), .pico(pico_a), .poci(poci)
  );

  spi_cfg_master #(.CS_GAP(1), .ADDR_W(7)) dut_b (
    .spi_clk(spi_clk), .rstn(rstn), .req(req_b),
    .req0_addr(req0_addr), .req1_addr(req1_addr),
    .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
    .req0_is_write(req0_is_write), .req1_is_write(req1_is_write),
    .gnt(gnt_b), .done(done_b), .rdata(rdata_b), .busy(busy_b),
    .cs(cs_b), .pico(pico_b), .poci(poci)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_gnt();
    for (int i = 0; i < 60; i++) begin
      @(negedge spi_clk);
      if (o_gnt != 2'b00) break;
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 60; i++) begin
      @(negedge spi_clk);
      if (!o_busy) break;
    end
    check({tag, " idle"}, 32'(o_busy), 32'd0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(negedge spi_clk);
    rstn = 1'b1;
  endtask

  // One full frame from gnt (T) to done (T+17); masks are ANDed into req at T+1 and T+17.
  task automatic do_frame(input string tag, input logic [1:0] exp_gnt,
                          input logic [15:0] exp_frame, input logic [7:0] rx_byte,
                          input logic [7:0] exp_rdata, input logic [1:0] mask_t1,
                          input logic [1:0] mask_done, output int t_gnt);
    logic [15:0] frame;
    logic [7:0]  rx_sh;
    int          bad;
    wait_gnt();
    t_gnt = cyc;
    check({tag, " gnt"}, 32'(o_gnt), 32'(exp_gnt));
    check({tag, " busy/cs at gnt"}, 32'({o_busy, o_cs, o_pico}), 32'(3'b100));
    frame = '0;
    rx_sh = rx_byte;
    bad   = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge spi_clk);
      if (k == 0) req = req & mask_t1;
      frame = {frame[14:0], o_pico};
      if (o_cs !== 1'b1 || o_done !== 2'b00 || o_gnt !== 2'b00 || o_busy !== 1'b1) bad++;
      if (k >= 8) begin
        poci  = rx_sh[7];
        rx_sh = {rx_sh[6:0], 1'b0};
      end else begin
        poci = 1'b0;
      end
    end
    @(negedge spi_clk);
    poci = 1'b0;
    check({tag, " frame"}, 32'(frame), 32'(exp_frame));
    check({tag, " ctl during frame"}, 32'(bad), 32'd0);
    check({tag, " done/cs/pico"}, 32'({o_done, o_cs, o_pico}), 32'({exp_gnt, 2'b00}));
    check({tag, " rdata"}, 32'(o_rdata), 32'(exp_rdata));
    req = req & mask_done;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int t1, t2, t3, bad, cnt;
    rstn = 1'b0; req = 2'b00; use_b = 1'b0; poci = 1'b0;
    req0_addr = '0; req1_addr = '0; req0_wdata = '0; req1_wdata = '0;
    req0_is_write = 1'b0; req1_is_write = 1'b0;
    repeat (3) @(negedge spi_clk);
    check("reset outs a", 32'({gnt_a, done_a, busy_a, cs_a, pico_a, rdata_a}), 32'd0);
    check("reset outs b", 32'({gnt_b, done_b, busy_b, cs_b, pico_b, rdata_b}), 32'd0);
    rstn = 1'b1;

    // Single write, requester 0.
    req0_is_write = 1'b1; req0_addr = 7'd4; req0_wdata = 8'h02; req = 2'b01;
    do_frame("wr0", 2'b01, 16'h8402, 8'h00, 8'h00, 2'b11, 2'b00, t1);
    @(negedge spi_clk);
    check("wr0 busy T+18", 32'(o_busy), 32'd1);
    @(negedge spi_clk);
    check("wr0 busy/gnt T+19", 32'({o_busy, o_gnt}), 32'd0);

    // Single read, requester 1.
    req1_is_write = 1'b0; req1_addr = 7'd2; req = 2'b10;
    do_frame("rd1", 2'b10, 16'h0200, 8'hA5, 8'hA5, 2'b11, 2'b00, t1);
    repeat (3) @(negedge spi_clk);
    check("rd1 rdata held", 32'(o_rdata), 32'h0000_00A5);
    wait_idle("rd1");

    // Reset at T+10 of a read; requester 0 pending across the reset.
    req0_is_write = 1'b0; req0_addr = 7'd9; req = 2'b10;
    wait_gnt();
    check("rstmid gnt", 32'(o_gnt), 32'(2'b10));
    poci = 1'b1;
    repeat (10) @(negedge spi_clk);
    rstn = 1'b0;
    req  = 2'b11;
    #1;
    check("rstmid outs zero", 32'({o_gnt, o_done, o_busy, o_cs, o_pico, o_rdata}), 32'd0);
    bad = 0;
    repeat (2) begin
      @(negedge spi_clk);
      if (o_done != 2'b00 || o_gnt != 2'b00 || o_busy) bad++;
    end
    check("rstmid quiet in reset", 32'(bad), 32'd0);
    rstn = 1'b1;
    poci = 1'b0;
    do_frame("rst regrant", 2'b01, 16'h0900, 8'h3C, 8'h3C, 2'b11, 2'b00, t1);
    wait_idle("rst regrant");

    // Simultaneous requests after reset, both held.
    do_reset();
    req0_is_write = 1'b1; req0_addr = 7'd1; req0_wdata = 8'h11;
    req1_is_write = 1'b1; req1_addr = 7'd3; req1_wdata = 8'h33;
    req = 2'b11;
    do_frame("rr0", 2'b01, 16'h8111, 8'h00, 8'h00, 2'b11, 2'b11, t1);
    do_frame("rr1", 2'b10, 16'h8333, 8'h00, 8'h00, 2'b11, 2'b11, t2);
    do_frame("rr2", 2'b01, 16'h8111, 8'h00, 8'h00, 2'b11, 2'b00, t3);
    check("rr spacing 1", 32'(t2 - t1), 32'd19);
    check("rr spacing 2", 32'(t3 - t2), 32'd19);
    wait_idle("rr");

    // Requester 1 drops req one cycle after grant.
    req1_is_write = 1'b1; req1_addr = 7'd6; req1_wdata = 8'h5A; req = 2'b10;
    do_frame("drop1", 2'b10, 16'h865A, 8'h00, 8'h00, 2'b01, 2'b00, t1);
    cnt = 0;
    repeat (40) begin
      @(negedge spi_clk);
      if (o_gnt != 2'b00) cnt++;
    end
    check("drop1 no regrant", 32'(cnt), 32'd0);

    // CS_GAP=1: write then read from requester 0 with req held.
    do_reset();
    use_b = 1'b1;
    req0_is_write = 1'b1; req0_addr = 7'd4; req0_wdata = 8'h77; req = 2'b01;
    do_frame("g1 wr", 2'b01, 16'h8477, 8'h00, 8'h00, 2'b11, 2'b11, t1);
    req0_is_write = 1'b0;
    // cs low spans the single gap cycle plus the grant cycle of the next frame.
    do_frame("g1 rd", 2'b01, 16'h0400, 8'hC3, 8'hC3, 2'b11, 2'b00, t2);
    check("g1 gnt spacing", 32'(t2 - t1), 32'd18);
    wait_idle("g1");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
